// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types and constants for the pipeline hazard controller:
//            FSM state encoding and ALU operand forward-select codes.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Hazard FSM: normal issue vs. multi-cycle mul/div occupying EX
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_t;

  // ALU operand source select
  localparam logic [1:0] FWD_NONE = 2'b00;  // register file
  localparam logic [1:0] FWD_WB   = 2'b01;  // writeback stage result
  localparam logic [1:0] FWD_MEM  = 2'b10;  // memory stage result

  // Width of the mul/div occupancy down-counter
  localparam int MD_CNT_W = 4;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/operand_forward.sv
`default_nettype none
// ============================================================================
// Module   : operand_forward
// Brief    : Forward-select for one EX source register. The younger (MEM)
//            producer wins over the older (WB) one; x0 is never forwarded.
// Revision : 1.0 - initial release
// ============================================================================
module operand_forward
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs_ex,
  input  logic [4:0] i_rd_mem,
  input  logic [4:0] i_rd_wb,
  input  logic       i_reg_write_mem,
  input  logic       i_reg_write_wb,
  output logic [1:0] o_fwd_sel
);

  // Pick the most recent in-flight producer of the source register
  always_comb begin
    o_fwd_sel = FWD_NONE;
    if (i_rs_ex != 5'd0) begin
      if (i_reg_write_mem && (i_rs_ex == i_rd_mem)) begin
        o_fwd_sel = FWD_MEM;
      end else if (i_reg_write_wb && (i_rs_ex == i_rd_wb)) begin
        o_fwd_sel = FWD_WB;
      end
    end
  end

endmodule : operand_forward
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Brief    : 5-stage pipeline hazard unit: operand forwarding, load-use
//            stall, taken-branch flush, multi-cycle mul/div occupancy and
//            saturating stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4,   // total EX cycles per mul/div op (2..16)
  parameter int CNT_W      = 16   // performance counter width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rs1_ex,
  input  logic [4:0]       rs2_ex,
  input  logic [4:0]       rd_ex,
  input  logic [4:0]       rd_mem,
  input  logic [4:0]       rd_wb,
  input  logic             register_write_mem,
  input  logic             register_write_wb,
  input  logic             mem_read_ex,
  input  logic             pc_src_ex,
  input  logic             muldiv_ex,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be,
  output logic             md_last,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // The RUN cycle that accepts the op is the first of MD_LATENCY cycles, and
  // the final (md_last) cycle is the one where the counter reads zero.
  localparam logic [MD_CNT_W-1:0] c_MD_LOAD  = MD_CNT_W'(MD_LATENCY - 2);
  localparam logic [CNT_W-1:0]    c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    c_CNT_MAX  = '1;

  hz_state_t             r_state;
  hz_state_t             w_state_nxt;
  logic [MD_CNT_W-1:0]   r_md_cnt;
  logic [MD_CNT_W-1:0]   w_md_cnt_nxt;
  logic [CNT_W-1:0]      r_stall_count;
  logic [CNT_W-1:0]      r_flush_count;
  logic                  w_load_use;
  logic                  w_branch_flush;
  logic [1:0]            w_fwd_a;
  logic [1:0]            w_fwd_b;

  operand_forward u_fwd_a (
    .i_rs_ex         (rs1_ex),
    .i_rd_mem        (rd_mem),
    .i_rd_wb         (rd_wb),
    .i_reg_write_mem (register_write_mem),
    .i_reg_write_wb  (register_write_wb),
    .o_fwd_sel       (w_fwd_a)
  );

  operand_forward u_fwd_b (
    .i_rs_ex         (rs2_ex),
    .i_rd_mem        (rd_mem),
    .i_rd_wb         (rd_wb),
    .i_reg_write_mem (register_write_mem),
    .i_reg_write_wb  (register_write_wb),
    .o_fwd_sel       (w_fwd_b)
  );

  // Forwarding is suppressed while the pipeline is held in reset
  assign forward_ae = reset ? FWD_NONE : w_fwd_a;
  assign forward_be = reset ? FWD_NONE : w_fwd_b;

  assign w_load_use = mem_read_ex && (rd_ex != 5'd0) &&
                      ((rd_ex == rs1_id) || (rd_ex == rs2_id));

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

  // Stall/flush decode and FSM next state; priority mul/div > branch > load-use
  always_comb begin
    stall_f        = 1'b0;
    stall_d        = 1'b0;
    stall_e        = 1'b0;
    flush_d        = 1'b0;
    flush_e        = 1'b0;
    flush_m        = 1'b0;
    md_last        = 1'b0;
    w_branch_flush = 1'b0;
    w_state_nxt    = r_state;
    w_md_cnt_nxt   = r_md_cnt;
    if (!reset) begin
      unique case (r_state)
        RUN: begin
          if (muldiv_ex) begin
            stall_f      = 1'b1;
            stall_d      = 1'b1;
            stall_e      = 1'b1;
            flush_m      = 1'b1;
            w_md_cnt_nxt = c_MD_LOAD;
            w_state_nxt  = MD_BUSY;
          end else if (pc_src_ex) begin
            flush_d        = 1'b1;
            flush_e        = 1'b1;
            w_branch_flush = 1'b1;
          end else if (w_load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        MD_BUSY: begin
          if (r_md_cnt != '0) begin
            stall_f      = 1'b1;
            stall_d      = 1'b1;
            stall_e      = 1'b1;
            flush_m      = 1'b1;
            w_md_cnt_nxt = r_md_cnt - MD_CNT_W'(1);
          end else begin
            md_last     = 1'b1;
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // FSM state and mul/div occupancy counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Saturating performance counters: stalled decode cycles and branch flushes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (stall_d && (r_stall_count != c_CNT_MAX)) begin
        r_stall_count <= r_stall_count + c_CNT_ONE;
      end
      if (w_branch_flush && (r_flush_count != c_CNT_MAX)) begin
        r_flush_count <= r_flush_count + c_CNT_ONE;
      end
    end
  end

endmodule : hazard_controller
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_controller
// Brief    : Self-checking bench for hazard_controller: directed scenarios and
//            randomized traffic compared against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

  localparam int MDL     = 4;
  localparam int CW      = 16;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic          register_write_mem, register_write_wb;
  logic          mem_read_ex, pc_src_ex, muldiv_ex;
  logic          stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
  logic [1:0]    forward_ae, forward_be;
  logic          md_last;
  logic [CW-1:0] stall_count, flush_count;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: position within a mul/div op (-1 = no op) and
  // the two event counts.
  int m_age   = -1;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MD_LATENCY(MDL), .CNT_W(CW)) dut (
    .clk                (clk),
    .reset              (reset),
    .rs1_id             (rs1_id),
    .rs2_id             (rs2_id),
    .rs1_ex             (rs1_ex),
    .rs2_ex             (rs2_ex),
    .rd_ex              (rd_ex),
    .rd_mem             (rd_mem),
    .rd_wb              (rd_wb),
    .register_write_mem (register_write_mem),
    .register_write_wb  (register_write_wb),
    .mem_read_ex        (mem_read_ex),
    .pc_src_ex          (pc_src_ex),
    .muldiv_ex          (muldiv_ex),
    .stall_f            (stall_f),
    .stall_d            (stall_d),
    .stall_e            (stall_e),
    .flush_d            (flush_d),
    .flush_e            (flush_e),
    .flush_m            (flush_m),
    .forward_ae         (forward_ae),
    .forward_be         (forward_be),
    .md_last            (md_last),
    .stall_count        (stall_count),
    .flush_count        (flush_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (register_write_mem && rs == rd_mem) return 2'b10;
    if (register_write_wb && rs == rd_wb) return 2'b01;
    return 2'b00;
  endfunction

  // One clock cycle: inputs are already driven (at negedge). Check the
  // combinational outputs, take the edge, advance the model, check counters.
  task automatic step(input string tag);
    logic sf, sd, se, fd, fe, fm, ml, br;
    logic [1:0] fa, fb;
    {sf, sd, se, fd, fe, fm, ml, br} = '0;
    fa = 2'b00;
    fb = 2'b00;
    if (!reset) begin
      fa = m_fwd(rs1_ex);
      fb = m_fwd(rs2_ex);
      if (m_age >= 0) begin
        if (m_age < MDL - 1) {sf, sd, se, fm} = 4'b1111;
        else ml = 1'b1;
      end else if (muldiv_ex) begin
        {sf, sd, se, fm} = 4'b1111;
      end else if (pc_src_ex) begin
        {fd, fe, br} = 3'b111;
      end else if (mem_read_ex && rd_ex != 5'd0 &&
                   (rd_ex == rs1_id || rd_ex == rs2_id)) begin
        {sf, sd, fe} = 3'b111;
      end
    end
    #1;
    check({tag, ".stall_f"}, 32'(stall_f), 32'(sf));
    check({tag, ".stall_d"}, 32'(stall_d), 32'(sd));
    check({tag, ".stall_e"}, 32'(stall_e), 32'(se));
    check({tag, ".flush_d"}, 32'(flush_d), 32'(fd));
    check({tag, ".flush_e"}, 32'(flush_e), 32'(fe));
    check({tag, ".flush_m"}, 32'(flush_m), 32'(fm));
    check({tag, ".md_last"}, 32'(md_last), 32'(ml));
    check({tag, ".fwd_a"}, 32'(forward_ae), 32'(fa));
    check({tag, ".fwd_b"}, 32'(forward_be), 32'(fb));
    @(posedge clk);
    if (reset) begin
      m_age   = -1;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (sd && m_stall < CNT_SAT) m_stall++;
      if (br && m_flush < CNT_SAT) m_flush++;
      if (m_age >= 0) m_age = (m_age == MDL - 1) ? -1 : m_age + 1;
      else if (muldiv_ex) m_age = 1;
    end
    #1;
    check({tag, ".stall_cnt"}, 32'(stall_count), 32'(m_stall));
    check({tag, ".flush_cnt"}, 32'(flush_count), 32'(m_flush));
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb} = '0;
    {register_write_mem, register_write_wb} = '0;
    {mem_read_ex, pc_src_ex, muldiv_ex} = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step("reset");
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);

    // Reset with every hazard input active: outputs must stay quiet
    {mem_read_ex, pc_src_ex, muldiv_ex} = 3'b111;
    {register_write_mem, register_write_wb} = 2'b11;
    rs1_ex = 5'd3; rd_mem = 5'd3; rs2_ex = 5'd4; rd_wb = 5'd4;
    rd_ex = 5'd6; rs1_id = 5'd6;
    step("rst_busy_inputs");
    do_reset();

    // Forwarding: MEM has priority over WB; x0 never forwarded
    rs1_ex = 5'd5; rd_mem = 5'd5; rd_wb = 5'd5;
    {register_write_mem, register_write_wb} = 2'b11;
    step("fwd_mem_prio");
    check("fwd_mem_prio.const", 32'(forward_ae), 32'(2'b10));
    rs1_ex = 5'd0; rd_mem = 5'd0;
    step("fwd_x0");
    check("fwd_x0.const", 32'(forward_ae), 32'(2'b00));

    // Load-use: one stall cycle
    do_reset();
    mem_read_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7;
    step("load_use");
    clear_inputs();
    step("load_use_after");
    check("load_use.stall_cnt_const", 32'(stall_count), 32'd1);

    // Load-use coinciding with a taken branch: branch wins
    do_reset();
    mem_read_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7; pc_src_ex = 1'b1;
    step("lu_branch");
    check("lu_branch.flush_cnt_const", 32'(flush_count), 32'd1);
    check("lu_branch.stall_cnt_const", 32'(stall_count), 32'd0);

    // Mul/div held high: 3 stall cycles then md_last
    do_reset();
    muldiv_ex = 1'b1;
    for (int i = 0; i < MDL; i++) step($sformatf("md_hold%0d", i));
    check("md_hold.stall_cnt_const", 32'(stall_count), 32'(MDL - 1));
    step("md_back_to_back");

    // Reset during the second MD_BUSY cycle abandons the op
    do_reset();
    muldiv_ex = 1'b1;
    step("md_abort_run");
    step("md_abort_busy1");
    reset = 1'b1;
    step("md_abort_reset");
    reset = 1'b0;
    muldiv_ex = 1'b0;
    step("md_abort_after");
    check("md_abort.stall_cnt_const", 32'(stall_count), 32'd0);
    check("md_abort.flush_cnt_const", 32'(flush_count), 32'd0);

    // Randomized traffic with small register indices to provoke matches
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset              = ($urandom_range(0, 49) == 0);
      rs1_id             = 5'($urandom_range(0, 3));
      rs2_id             = 5'($urandom_range(0, 3));
      rs1_ex             = 5'($urandom_range(0, 3));
      rs2_ex             = 5'($urandom_range(0, 3));
      rd_ex              = 5'($urandom_range(0, 3));
      rd_mem             = 5'($urandom_range(0, 3));
      rd_wb              = 5'($urandom_range(0, 3));
      register_write_mem = 1'($urandom_range(0, 1));
      register_write_wb  = 1'($urandom_range(0, 1));
      mem_read_ex        = ($urandom_range(0, 2) == 0);
      pc_src_ex          = ($urandom_range(0, 5) == 0);
      muldiv_ex          = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    // Counter saturation under sustained load-use
    do_reset();
    mem_read_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7;
    for (int i = 0; i < 70000; i++) step("sat");
    check("sat.stall_cnt_const", 32'(stall_count), 32'(CNT_SAT));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_hazard_controller
`default_nettype wire
